// File: rtl/sonar_scanner.sv
// Round-robin controller for NUM_SONARS ultrasonic rangefinders: one slot per
// enabled channel, each slot fires a trigger pulse, times the echo and publishes a result.
module sonar_scanner #(
  parameter int NUM_SONARS  = 3,
  parameter int CNT_W       = 20,
  parameter int TRIG_CYCLES = 500,
  parameter int SLOT_CYCLES = 882400,
  localparam int CH_W = (NUM_SONARS > 1) ? $clog2(NUM_SONARS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [NUM_SONARS-1:0]       chan_mask,
  input  logic [NUM_SONARS-1:0]       echo,
  output logic [NUM_SONARS-1:0]       trig,
  output logic [NUM_SONARS*CNT_W-1:0] range,
  output logic [NUM_SONARS-1:0]       range_valid,
  output logic [NUM_SONARS-1:0]       timeout,
  output logic                        upd_stb,
  output logic [CH_W-1:0]             upd_chan
);

  localparam int TMR_W = $clog2(SLOT_CYCLES);
  localparam logic [TMR_W-1:0] SLOT_LAST = TMR_W'(SLOT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TRIG_LAST = TMR_W'(TRIG_CYCLES - 1);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_SONARS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_LISTEN,
    S_ECHO,
    S_HOLD
  } state_t;

  state_t                      state_q, state_d;
  logic [TMR_W-1:0]            timer_q, timer_d;
  logic [CH_W-1:0]             cur_q, cur_d;
  logic [CH_W-1:0]             ptr_q, ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [NUM_SONARS-1:0]       trig_q, trig_d;
  logic [NUM_SONARS*CNT_W-1:0] range_q, range_d;
  logic [NUM_SONARS-1:0]       valid_q, valid_d;
  logic [NUM_SONARS-1:0]       tmo_q, tmo_d;
  logic                        upd_stb_q, upd_stb_d;
  logic [CH_W-1:0]             upd_chan_q, upd_chan_d;

  logic [NUM_SONARS-1:0]       echo_meta_q;
  logic [NUM_SONARS-1:0]       es_q;
  logic [NUM_SONARS-1:0]       es_prev_q;

  logic [CH_W-1:0]             nxt_ch;
  logic [CH_W-1:0]             start_ch;
  logic                        scan_ok;
  logic                        es_cur;
  logic                        es_rise;

  // First set bit of mask at or above start, wrapping past the top channel.
  function automatic logic [CH_W-1:0] find_next(input logic [NUM_SONARS-1:0] mask,
                                                input logic [CH_W-1:0] start);
    logic [NUM_SONARS-1:0] rot;
    int off;
    int s;
    rot = NUM_SONARS'({mask, mask} >> start);
    off = 0;
    for (int k = NUM_SONARS - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    s = int'(start) + off;
    if (s >= NUM_SONARS) s = s - NUM_SONARS;
    return CH_W'(s);
  endfunction

  function automatic logic [NUM_SONARS-1:0] onehot(input logic [CH_W-1:0] ch);
    logic [NUM_SONARS-1:0] v;
    v = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_meta_q <= '0;
      es_q        <= '0;
      es_prev_q   <= '0;
      state_q     <= S_IDLE;
      timer_q     <= '0;
      cur_q       <= '0;
      ptr_q       <= '0;
      count_q     <= '0;
      trig_q      <= '0;
      range_q     <= '0;
      valid_q     <= '0;
      tmo_q       <= '0;
      upd_stb_q   <= 1'b0;
      upd_chan_q  <= '0;
    end else begin
      echo_meta_q <= echo;
      es_q        <= echo_meta_q;
      es_prev_q   <= es_q;
      state_q     <= state_d;
      timer_q     <= timer_d;
      cur_q       <= cur_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      trig_q      <= trig_d;
      range_q     <= range_d;
      valid_q     <= valid_d;
      tmo_q       <= tmo_d;
      upd_stb_q   <= upd_stb_d;
      upd_chan_q  <= upd_chan_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cur_d      = cur_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    trig_d     = trig_q;
    range_d    = range_q;
    valid_d    = valid_q;
    tmo_d      = tmo_q;
    upd_stb_d  = 1'b0;
    upd_chan_d = upd_chan_q;

    nxt_ch   = (cur_q == LAST_CH) ? '0 : cur_q + 1'b1;
    scan_ok  = en && (|chan_mask);
    es_cur   = es_q[cur_q];
    // Edge detection against the previous sample means a level already high
    // on entry to LISTEN is not mistaken for a fresh echo.
    es_rise  = es_cur && !es_prev_q[cur_q];
    start_ch = find_next(chan_mask, (state_q == S_IDLE) ? ptr_q : nxt_ch);

    if (state_q == S_IDLE) begin
      trig_d = '0;
      if (scan_ok) begin
        state_d = S_TRIG;
        timer_d = '0;
        cur_d   = start_ch;
        count_d = '0;
        trig_d  = onehot(start_ch);
      end
    end else begin
      timer_d = timer_q + 1'b1;
      case (state_q)
        S_TRIG: begin
          if (timer_q == TRIG_LAST) begin
            trig_d  = '0;
            state_d = S_LISTEN;
          end
        end
        S_LISTEN: begin
          if (es_rise) begin
            count_d = CNT_W'(1);
            state_d = S_ECHO;
          end
        end
        S_ECHO: begin
          if (es_cur) begin
            if (count_q != CNT_MAX) count_d = count_q + 1'b1;
          end else begin
            state_d = S_HOLD;
          end
        end
        default: ;
      endcase

      // Slot end overrides whatever the per-state logic decided above.
      if (timer_q == SLOT_LAST) begin
        if (state_q == S_HOLD) begin
          range_d[int'(cur_q)*CNT_W +: CNT_W] = count_q;
          valid_d[cur_q] = 1'b1;
          tmo_d[cur_q]   = 1'b0;
        end else begin
          valid_d[cur_q] = 1'b0;
          tmo_d[cur_q]   = 1'b1;
        end
        upd_stb_d  = 1'b1;
        upd_chan_d = cur_q;
        ptr_d      = nxt_ch;
        timer_d    = '0;
        count_d    = '0;
        if (scan_ok) begin
          state_d = S_TRIG;
          cur_d   = start_ch;
          trig_d  = onehot(start_ch);
        end else begin
          state_d = S_IDLE;
          trig_d  = '0;
        end
      end
    end
  end

  assign trig        = trig_q;
  assign range       = range_q;
  assign range_valid = valid_q;
  assign timeout     = tmo_q;
  assign upd_stb     = upd_stb_q;
  assign upd_chan    = upd_chan_q;

endmodule

// File: tb/tb_sonar_scanner.sv
// Randomised scoreboard bench for sonar_scanner: two instances (8- and 6-bit
// counters) share stimulus; a monitor checks every published slot result.
module tb_sonar_scanner;
  localparam int N    = 3;
  localparam int TRIG = 10;
  localparam int SLOT = 200;
  localparam int W8   = 8;
  localparam int W6   = 6;
  localparam int MAX8 = 255;
  localparam int MAX6 = 63;
  localparam int K_GOOD  = 0;
  localparam int K_NONE  = 1;
  localparam int K_STUCK = 2;
  localparam int K_PRE   = 3;

  logic clk = 1'b0;
  logic reset, en;
  logic [N-1:0] chan_mask, echo;
  logic [N-1:0] trig, trig6, rv8, rv6, to8, to6;
  logic [N*W8-1:0] rng8;
  logic [N*W6-1:0] rng6;
  logic stb8, stb6;
  logic [1:0] ch8, ch6;

  always #5 clk = ~clk;

  sonar_scanner #(.NUM_SONARS(N), .CNT_W(W8), .TRIG_CYCLES(TRIG), .SLOT_CYCLES(SLOT)) dut8 (
    .clk(clk), .reset(reset), .en(en), .chan_mask(chan_mask), .echo(echo),
    .trig(trig), .range(rng8), .range_valid(rv8), .timeout(to8),
    .upd_stb(stb8), .upd_chan(ch8));

  sonar_scanner #(.NUM_SONARS(N), .CNT_W(W6), .TRIG_CYCLES(TRIG), .SLOT_CYCLES(SLOT)) dut6 (
    .clk(clk), .reset(reset), .en(en), .chan_mask(chan_mask), .echo(echo),
    .trig(trig6), .range(rng6), .range_valid(rv6), .timeout(to6),
    .upd_stb(stb6), .upd_chan(ch6));

  typedef struct packed {
    logic [1:0]            ch;
    logic [N-1:0]          v;
    logic [N-1:0]          t;
    logic [N-1:0][15:0]    r;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int onehot_viol = 0;
  int t1_seen = 0;
  bit watch1 = 0;

  // Reference model state: what each channel should currently be showing.
  int m_rng[N];
  logic [N-1:0] m_v, m_t;
  int m_ptr, m_next;
  bit m_cont;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if ($countones(trig) > 1 || $countones(trig6) > 1) onehot_viol <= onehot_viol + 1;
    if (watch1 && trig[1]) t1_seen <= t1_seen + 1;
  end

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic int first_en(input logic [N-1:0] m, input int start);
    for (int k = 0; k < N; k++) if (m[(start + k) % N]) return (start + k) % N;
    return start;
  endfunction

  // Echo width may legitimately read +/-1; a width beyond the counter range must read full scale.
  function automatic bit close(input int act, input int w, input int mx);
    if (w == 0) return act == 0;
    if (w > mx) return act == mx;
    return (act >= w - 1) && (act <= w + 1);
  endfunction

  function automatic int sat(input int w, input int mx);
    return (w > mx) ? mx : w;
  endfunction

  // Monitor: pops one expectation per published result.
  initial begin
    exp_t e;
    bit ok8, ok6;
    logic [N*W8-1:0] x8;
    logic [N*W6-1:0] x6;
    forever begin
      @(negedge clk);
      if (!reset && stb8) begin
        if (q.size() == 0) begin
          check("unexpected_upd", 1'b0, {30'd0, ch8}, 0);
        end else begin
          e = q.pop_front();
          ok8 = 1'b1;
          ok6 = 1'b1;
          for (int c = 0; c < N; c++) begin
            ok8 &= close(int'(rng8[c*W8 +: W8]), int'(e.r[c]), MAX8);
            ok6 &= close(int'(rng6[c*W6 +: W6]), int'(e.r[c]), MAX6);
            x8[c*W8 +: W8] = W8'(sat(int'(e.r[c]), MAX8));
            x6[c*W6 +: W6] = W6'(sat(int'(e.r[c]), MAX6));
          end
          $display("[TB] upd ch=%0d valid=%b timeout=%b range8=%h range6=%h", ch8, rv8, to8, rng8, rng6);
          check("upd_chan", ch8 == e.ch && ch6 == e.ch, {ch6, ch8}, {e.ch, e.ch});
          check("stb6", stb6 == 1'b1, stb6, 1);
          check("valid", rv8 == e.v && rv6 == e.v, {rv6, rv8}, {e.v, e.v});
          check("timeout", to8 == e.t && to6 == e.t, {to6, to8}, {e.t, e.t});
          check("range8", ok8, rng8, x8);
          check("range6", ok6, rng6, x6);
        end
      end
    end
  end

  // One slot on the channel the model predicts; kind selects the echo pattern.
  task automatic do_slot(input int kind, input int d, input int w);
    int n, hi, ch, s_cyc;
    exp_t e;
    logic [N-1:0] oh;
    ch = m_next;
    oh = '0;
    oh[ch] = 1'b1;
    n = 0;
    while (trig == '0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    s_cyc = cyc;
    check("slot_start_lat", n == (m_cont ? 0 : 1), n, m_cont ? 0 : 1);
    check("trig_chan", trig == oh && trig6 == oh, {trig6, trig}, {oh, oh});
    if (kind == K_GOOD) begin
      m_rng[ch] = w;
      m_v[ch] = 1'b1;
      m_t[ch] = 1'b0;
    end else begin
      m_v[ch] = 1'b0;
      m_t[ch] = 1'b1;
    end
    e.ch = 2'(ch);
    e.v = m_v;
    e.t = m_t;
    for (int c = 0; c < N; c++) e.r[c] = 16'(m_rng[c]);
    q.push_back(e);

    hi = 0;
    while (trig[ch] && hi < 100) begin
      if (kind == K_PRE && hi == 3) echo[ch] = 1'b1;
      @(negedge clk);
      hi++;
    end
    check("trig_width", hi == TRIG, hi, TRIG);

    if (kind == K_GOOD || kind == K_STUCK) begin
      repeat (d) @(negedge clk);
      echo[ch] = 1'b1;
      if (kind == K_GOOD) begin
        repeat (w) @(negedge clk);
        echo[ch] = 1'b0;
      end
    end
    n = 0;
    while (!stb8 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("slot_len", cyc - s_cyc == SLOT, cyc - s_cyc, SLOT);
    echo[ch] = 1'b0;
    m_ptr = (ch + 1) % N;
    if (en && chan_mask != '0) begin
      m_next = first_en(chan_mask, m_ptr);
      m_cont = 1'b1;
    end else begin
      m_cont = 1'b0;
    end
  endtask

  task automatic rand_slot();
    do_slot(int'($urandom_range(0, 3)), int'($urandom_range(1, 60)), int'($urandom_range(1, 100)));
  endtask

  task automatic start_scan();
    en = 1'b1;
    m_next = first_en(chan_mask, m_ptr);
    m_cont = 1'b0;
  endtask

  task automatic check_idle(input int cycles);
    int bad;
    bad = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (trig != '0 || trig6 != '0 || stb8) bad++;
    end
    check("idle_quiet", bad == 0, bad, 0);
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) m_rng[c] = 0;
    m_v = '0;
    m_t = '0;
    m_ptr = 0;
    m_next = 0;
    m_cont = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0;
    chan_mask = '0;
    echo = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_trig", trig == '0 && trig6 == '0, {trig6, trig}, 0);
    check("rst_range", rng8 == '0 && rng6 == '0, rng8, 0);
    check("rst_flags", rv8 == '0 && to8 == '0 && rv6 == '0 && to6 == '0, {rv8, to8}, 0);
    check("rst_upd", stb8 == 1'b0 && ch8 == '0, {stb8, ch8}, 0);
    reset = 1'b0;
    check_idle(20);

    // Directed opening: good echo, no echo, stuck echo, echo high before trig end.
    chan_mask = 3'b111;
    start_scan();
    do_slot(K_GOOD, 20, 37);
    do_slot(K_NONE, 0, 0);
    do_slot(K_STUCK, 30, 0);
    do_slot(K_PRE, 0, 0);
    repeat (6) rand_slot();

    // Channel 1 masked off; the slot already running finishes first.
    chan_mask = 3'b101;
    rand_slot();
    watch1 = 1'b1;
    repeat (4) rand_slot();
    watch1 = 1'b0;
    check("trig1_masked", t1_seen == 0, t1_seen, 0);

    // Mask cleared mid-slot: that slot still publishes, then idle.
    chan_mask = 3'b000;
    rand_slot();
    check_idle(300);

    chan_mask = 3'b111;
    start_scan();
    rand_slot();
    en = 1'b0;
    rand_slot();
    check_idle(50);
    start_scan();
    do_slot(K_GOOD, 5, 100);
    rand_slot();

    // Next slot is channel 1: hit reset while its trigger is high.
    repeat (2) @(negedge clk);
    check("pre_reset_trig1", trig[1] == 1'b1, trig, 3'b010);
    #2 reset = 1'b1;
    #1;
    check("async_rst_trig", trig == '0 && trig6 == '0, {trig6, trig}, 0);
    check("async_rst_out", rng8 == '0 && rv8 == '0 && to8 == '0 && stb8 == 1'b0 && ch8 == '0,
          {rng8, rv8, to8}, 0);
    q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_slot(K_GOOD, 12, 25);
    repeat (3) rand_slot();

    check("queue_drained", q.size() == 0, q.size(), 0);
    check("trig_onehot", onehot_viol == 0, onehot_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
